// File: rtl/expr_pkg.sv
// Shared definitions for the serial expression recognizer/evaluator family:
// state codes, ASCII constants and the character-class encoding.
package expr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    NUM  = 2'b01,
    OP   = 2'b10,
    DEAD = 2'b11
  } state_e;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'b00,
    CLS_DIGIT = 2'b01,
    CLS_OP    = 2'b10
  } char_class_e;

  function automatic char_class_e encode_class(input logic is_digit, input logic is_op);
    if (is_digit)   return CLS_DIGIT;
    else if (is_op) return CLS_OP;
    else            return CLS_OTHER;
  endfunction

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier shared by the recognizer and evaluator.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic       is_op,
  output logic       is_mul,
  output logic [3:0] digit
);

  assign is_digit = (in >= CH_0) && (in <= CH_9);
  assign is_mul   = (in == CH_STAR);
  assign is_op    = is_mul || (in == CH_PLUS);
  // '0'..'9' are 0x30..0x39, so the low nibble already is the digit value.
  assign digit    = in[3:0];

endmodule

// File: rtl/expr_eval.sv
// Serial evaluator for single-digit '+'/'*' expressions; '*' binds tighter
// than '+' by keeping the pending product in term and the rest in sum.
module expr_eval
  import expr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic [WIDTH-1:0] value,
  output logic             out_valid,
  output logic             ovf,
  output logic             dead
);

  logic        is_digit, is_op, is_mul;
  logic [3:0]  digit;
  char_class_e cls;

  expr_char_class u_class (
    .in       (in),
    .is_digit (is_digit),
    .is_op    (is_op),
    .is_mul   (is_mul),
    .digit    (digit)
  );

  assign cls = encode_class(is_digit, is_op);

  state_e           st_q, st_d;
  logic [WIDTH-1:0] sum_q, sum_d, term_q, term_d;
  logic             pend_mul_q, pend_mul_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH+3:0] prod;
  logic [WIDTH:0]   add;
  logic [WIDTH-1:0] digit_w;

  assign digit_w = {{(WIDTH-4){1'b0}}, digit};
  assign prod    = {4'b0000, term_q} * {{WIDTH{1'b0}}, digit};
  assign add     = {1'b0, sum_q} + {1'b0, term_q};

  assign value     = add[WIDTH-1:0];
  assign out_valid = (st_q == NUM);
  assign ovf       = (st_q == NUM) && (ovf_q || add[WIDTH]);
  assign dead      = (st_q == DEAD);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the case leaves one unassigned and infers a latch.
    st_d       = st_q;
    sum_d      = sum_q;
    term_d     = term_q;
    pend_mul_d = pend_mul_q;
    ovf_d      = ovf_q;
    if (in_valid) begin
      unique case (st_q)
        IDLE: begin
          if (cls == CLS_DIGIT) begin
            st_d   = NUM;
            sum_d  = '0;
            term_d = digit_w;
            ovf_d  = 1'b0;
          end else if (cls == CLS_OP) begin
            st_d = DEAD;
          end
        end
        NUM: begin
          if (cls == CLS_OP) begin
            st_d       = OP;
            pend_mul_d = is_mul;
          end else if (cls == CLS_DIGIT) begin
            st_d = DEAD;
          end else begin
            st_d   = IDLE;
            sum_d  = '0;
            term_d = '0;
            ovf_d  = 1'b0;
          end
        end
        OP: begin
          if (cls == CLS_DIGIT) begin
            st_d = NUM;
            if (pend_mul_q) begin
              term_d = prod[WIDTH-1:0];
              ovf_d  = ovf_q || (prod[WIDTH+3:WIDTH] != 4'h0);
            end else begin
              sum_d  = add[WIDTH-1:0];
              term_d = digit_w;
              ovf_d  = ovf_q || add[WIDTH];
            end
          end else if (cls == CLS_OP) begin
            st_d = DEAD;
          end else begin
            st_d   = IDLE;
            sum_d  = '0;
            term_d = '0;
            ovf_d  = 1'b0;
          end
        end
        DEAD: ;
      endcase
    end
  end

  // NOTE: clr is asynchronous so a mid-expression reset clears the outputs
  // immediately; state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_q       <= IDLE;
      sum_q      <= '0;
      term_q     <= '0;
      pend_mul_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      sum_q      <= sum_d;
      term_q     <= term_d;
      pend_mul_q <= pend_mul_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: a 16-bit and an 8-bit instance share one stimulus stream;
// expected outputs come from hand-computed vector tables.
module tb_expr_eval;

  typedef struct {
    logic        v;
    logic [7:0]  ch;
    logic [15:0] val;   // 16-bit value; the 8-bit instance expects val[7:0]
    logic        odv;
    logic        ov;    // ovf of the 16-bit instance
    logic        ov8;   // ovf of the 8-bit instance
    logic        dd;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in = 8'h00;

  logic [15:0] w_value;
  logic        w_out_valid, w_ovf, w_dead;
  logic [7:0]  n_value;
  logic        n_out_valid, n_ovf, n_dead;

  int checks = 0;
  int failures = 0;
  int step_no = 0;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  expr_eval #(.WIDTH(16)) dut16 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .value(w_value), .out_valid(w_out_valid), .ovf(w_ovf), .dead(w_dead)
  );

  expr_eval #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .value(n_value), .out_valid(n_out_valid), .ovf(n_ovf), .dead(n_dead)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] ch, input logic [15:0] val,
                              input logic odv, input logic ov, input logic ov8, input logic dd);
    vec_t e;
    e.v = v; e.ch = ch; e.val = val; e.odv = odv; e.ov = ov; e.ov8 = ov8; e.dd = dd;
    return e;
  endfunction

  task automatic compare(input string tag, input vec_t e);
    check({tag, " value16"}, 32'(w_value), 32'(e.val));
    check({tag, " out_valid16"}, 32'(w_out_valid), 32'(e.odv));
    check({tag, " ovf16"}, 32'(w_ovf), 32'(e.ov));
    check({tag, " dead16"}, 32'(w_dead), 32'(e.dd));
    check({tag, " value8"}, 32'(n_value), 32'(e.val[7:0]));
    check({tag, " out_valid8"}, 32'(n_out_valid), 32'(e.odv));
    check({tag, " ovf8"}, 32'(n_ovf), 32'(e.ov8));
    check({tag, " dead8"}, 32'(n_dead), 32'(e.dd));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t e);
    vec_t got;
    @(negedge clk);
    in_valid = e.v;
    in       = e.ch;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    compare($sformatf("step%0d '%c' v=%0d", step_no, got.ch, got.v), got);
    step_no++;
  endtask

  // Pulse clr between clock edges and confirm the outputs clear without a clock.
  task automatic pulse_clr(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    #2 clr = 1'b0;
    #1 compare({tag, " async clr"}, mk(1'b0, 8'h00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 clr = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // "1+2*3" then restart
    vecs.push_back(mk(1, "1", 16'd1,  1, 0, 0, 0));
    vecs.push_back(mk(1, "+", 16'd1,  0, 0, 0, 0));
    vecs.push_back(mk(1, "2", 16'd3,  1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd3,  0, 0, 0, 0));
    vecs.push_back(mk(1, "3", 16'd7,  1, 0, 0, 0));
    vecs.push_back(mk(1, " ", 16'd0,  0, 0, 0, 0));
    // "2*3+4*5" back to back
    vecs.push_back(mk(1, "2", 16'd2,  1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd2,  0, 0, 0, 0));
    vecs.push_back(mk(1, "3", 16'd6,  1, 0, 0, 0));
    vecs.push_back(mk(1, "+", 16'd6,  0, 0, 0, 0));
    vecs.push_back(mk(1, "4", 16'd10, 1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd10, 0, 0, 0, 0));
    vecs.push_back(mk(1, "5", 16'd26, 1, 0, 0, 0));
    vecs.push_back(mk(1, " ", 16'd0,  0, 0, 0, 0));
    // "2*3+4*5" with bubbles carrying a digit that must be ignored
    vecs.push_back(mk(1, "2", 16'd2,  1, 0, 0, 0));
    vecs.push_back(mk(0, "9", 16'd2,  1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd2,  0, 0, 0, 0));
    vecs.push_back(mk(0, "9", 16'd2,  0, 0, 0, 0));
    vecs.push_back(mk(1, "3", 16'd6,  1, 0, 0, 0));
    vecs.push_back(mk(0, "+", 16'd6,  1, 0, 0, 0));
    vecs.push_back(mk(1, "+", 16'd6,  0, 0, 0, 0));
    vecs.push_back(mk(0, "9", 16'd6,  0, 0, 0, 0));
    vecs.push_back(mk(1, "4", 16'd10, 1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd10, 0, 0, 0, 0));
    vecs.push_back(mk(0, "9", 16'd10, 0, 0, 0, 0));
    vecs.push_back(mk(1, "5", 16'd26, 1, 0, 0, 0));
    vecs.push_back(mk(0, "x", 16'd26, 1, 0, 0, 0));
    vecs.push_back(mk(1, " ", 16'd0,  0, 0, 0, 0));
    // "1+2x3": the 'x' restarts the stream
    vecs.push_back(mk(1, "1", 16'd1,  1, 0, 0, 0));
    vecs.push_back(mk(1, "+", 16'd1,  0, 0, 0, 0));
    vecs.push_back(mk(1, "2", 16'd3,  1, 0, 0, 0));
    vecs.push_back(mk(1, "x", 16'd0,  0, 0, 0, 0));
    vecs.push_back(mk(1, "3", 16'd3,  1, 0, 0, 0));
    vecs.push_back(mk(1, " ", 16'd0,  0, 0, 0, 0));
    // "9*9*9": 729 wraps to 217 in 8 bits via the product upper bits; then "x4"
    vecs.push_back(mk(1, "9", 16'd9,   1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd9,   0, 0, 0, 0));
    vecs.push_back(mk(1, "9", 16'd81,  1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd81,  0, 0, 0, 0));
    vecs.push_back(mk(1, "9", 16'd729, 1, 0, 1, 0));
    vecs.push_back(mk(1, "x", 16'd0,   0, 0, 0, 0));
    vecs.push_back(mk(1, "4", 16'd4,   1, 0, 0, 0));
    vecs.push_back(mk(1, " ", 16'd0,   0, 0, 0, 0));
    // "9*9*3+9*9+1": 8-bit sum carry shows combinationally, then sticks
    vecs.push_back(mk(1, "9", 16'd9,   1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd9,   0, 0, 0, 0));
    vecs.push_back(mk(1, "9", 16'd81,  1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd81,  0, 0, 0, 0));
    vecs.push_back(mk(1, "3", 16'd243, 1, 0, 0, 0));
    vecs.push_back(mk(1, "+", 16'd243, 0, 0, 0, 0));
    vecs.push_back(mk(1, "9", 16'd252, 1, 0, 0, 0));
    vecs.push_back(mk(1, "*", 16'd252, 0, 0, 0, 0));
    vecs.push_back(mk(1, "9", 16'd324, 1, 0, 1, 0));
    vecs.push_back(mk(1, "+", 16'd324, 0, 0, 0, 0));
    vecs.push_back(mk(1, "1", 16'd325, 1, 0, 1, 0));
    vecs.push_back(mk(1, " ", 16'd0,   0, 0, 0, 0));

    // Reset state, checked before any clock edge.
    #1 compare("reset", mk(1'b0, 8'h00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    clr = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // "+1": leading operator kills the stream; DEAD absorbs the digit.
    step(mk(1, "+", 16'd0, 0, 0, 0, 1));
    step(mk(1, "1", 16'd0, 0, 0, 0, 1));
    step(mk(1, " ", 16'd0, 0, 0, 0, 1));
    pulse_clr("after +1");

    // "12": multi-digit number is illegal; registers hold in DEAD.
    step(mk(1, "1", 16'd1, 1, 0, 0, 0));
    step(mk(1, "2", 16'd1, 0, 0, 0, 1));
    pulse_clr("after 12");
    step(mk(1, "5", 16'd5, 1, 0, 0, 0));
    step(mk(1, " ", 16'd0, 0, 0, 0, 0));

    // Asynchronous clear in the middle of "3*4".
    step(mk(1, "3", 16'd3, 1, 0, 0, 0));
    step(mk(1, "*", 16'd3, 0, 0, 0, 0));
    pulse_clr("mid 3*4");
    step(mk(1, "7", 16'd7, 1, 0, 0, 0));

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d leftover entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
